// File: rtl/alu_arbiter_if.sv
// Request/response channels of the two ALU clients plus the ALU-side bus,
// bundled for the arbiter. The arbiter takes the slave view; the clients
// and the ALU together take the master view.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [2:0]       req_cmd0;
   logic [2:0]       req_cmd1;
   logic [WIDTH-1:0] req_a0;
   logic [WIDTH-1:0] req_b0;
   logic [WIDTH-1:0] req_a1;
   logic [WIDTH-1:0] req_b1;

   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [WIDTH-1:0] rsp_res;
   logic             rsp_zero;
   logic             rsp_err;

   logic [2:0]       alu_cmd;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_res;
   logic             alu_zero;

   modport slave (
      input  req_valid, req_cmd0, req_cmd1, req_a0, req_b0, req_a1, req_b1,
      output req_ready,
      output rsp_valid, rsp_res, rsp_zero, rsp_err,
      input  rsp_ready,
      output alu_cmd, alu_a, alu_b,
      input  alu_res, alu_zero
   );

   modport master (
      output req_valid, req_cmd0, req_cmd1, req_a0, req_b0, req_a1, req_b1,
      input  req_ready,
      input  rsp_valid, rsp_res, rsp_zero, rsp_err,
      output rsp_ready,
      input  alu_cmd, alu_a, alu_b,
      output alu_res, alu_zero
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// A granted request is registered onto the ALU inputs for one cycle (EXEC),
// the ALU result is captured and held on the winner's response channel
// (RESP) until that requester consumes it.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);

   localparam logic [2:0] CMD_ILLEGAL = 3'b011;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t           state;
   logic             last;       // most recent grant
   logic             grant;      // requester being served
   logic             sel;        // requester that would win this cycle
   logic [2:0]       alu_cmd_q;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [1:0]       rsp_valid_q;
   logic [WIDTH-1:0] rsp_res_q;
   logic             rsp_zero_q;
   logic             rsp_err_q;

   // Round-robin pick: on contention the requester not served last wins.
   always_comb begin
      // NOTE: default assignment first so every path drives sel; no latch.
      sel = 1'b0;
      if (bus.req_valid == 2'b11) begin
         sel = ~last;
      end else begin
         sel = bus.req_valid[1];
      end
   end

   assign bus.req_ready = (state == IDLE && |bus.req_valid)
                          ? (sel ? 2'b10 : 2'b01) : 2'b00;

   // Control FSM; the ALU operand registers double as the latched request
   // and are zeroed outside EXEC so the ALU stays quiet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last        <= 1'b1;
         grant       <= 1'b0;
         alu_cmd_q   <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         rsp_valid_q <= 2'b00;
         rsp_res_q   <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples
         // pre-edge values regardless of statement order.
         case (state)
            IDLE: begin
               if (|bus.req_valid) begin
                  grant     <= sel;
                  last      <= sel;
                  alu_cmd_q <= sel ? bus.req_cmd1 : bus.req_cmd0;
                  alu_a_q   <= sel ? bus.req_a1   : bus.req_a0;
                  alu_b_q   <= sel ? bus.req_b1   : bus.req_b0;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               if (alu_cmd_q == CMD_ILLEGAL) begin
                  rsp_res_q  <= '0;
                  rsp_zero_q <= 1'b1;
                  rsp_err_q  <= 1'b1;
               end else begin
                  rsp_res_q  <= bus.alu_res;
                  rsp_zero_q <= bus.alu_zero;
                  rsp_err_q  <= 1'b0;
               end
               rsp_valid_q <= grant ? 2'b10 : 2'b01;
               alu_cmd_q   <= '0;
               alu_a_q     <= '0;
               alu_b_q     <= '0;
               state       <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready[grant]) begin
                  rsp_valid_q <= 2'b00;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.alu_cmd   = alu_cmd_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_res   = rsp_res_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU hangs off the ALU bus, a table of
// single-requester operations is run through the full handshake, followed by
// hand-written contention, backpressure and async-reset sequences.
module tb_alu_arbiter;

   localparam int WIDTH = 32;

   logic clk;
   logic rst;

   alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

   alu_arbiter #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; 011 returns garbage that the arbiter must discard.
   always_comb begin
      case (bus.alu_cmd)
         3'b000:  bus.alu_res = bus.alu_a & bus.alu_b;
         3'b001:  bus.alu_res = bus.alu_a | bus.alu_b;
         3'b010:  bus.alu_res = bus.alu_a + bus.alu_b;
         3'b100:  bus.alu_res = bus.alu_a & ~bus.alu_b;
         3'b101:  bus.alu_res = bus.alu_a | ~bus.alu_b;
         3'b110:  bus.alu_res = bus.alu_a - bus.alu_b;
         3'b111:  bus.alu_res = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
         default: bus.alu_res = 32'hDEAD_BEEF;
      endcase
      bus.alu_zero = (bus.alu_cmd == 3'b011) ? 1'b0 : (bus.alu_res == '0);
   end

   int total;
   int passed;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req_ready"}, 32'(bus.req_ready), 32'h0);
      check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
      check({tag, " rsp_res"},   bus.rsp_res,        32'h0);
      check({tag, " rsp_zero"},  32'(bus.rsp_zero),  32'h0);
      check({tag, " rsp_err"},   32'(bus.rsp_err),   32'h0);
      check({tag, " alu_cmd"},   32'(bus.alu_cmd),   32'h0);
      check({tag, " alu_a"},     bus.alu_a,          32'h0);
      check({tag, " alu_b"},     bus.alu_b,          32'h0);
   endtask

   typedef struct {
      logic        sel;
      logic [2:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        err;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [1:0] onehot(input logic s);
      return s ? 2'b10 : 2'b01;
   endfunction

   initial begin
      logic [31:0] held;
      total  = 0;
      passed = 0;

      vecs[0] = '{1'b0, 3'b010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
      vecs[1] = '{1'b1, 3'b110, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
      vecs[2] = '{1'b0, 3'b111, 32'd3,          32'd4,          32'd1,          1'b0, 1'b0};
      vecs[3] = '{1'b1, 3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b1};
      vecs[4] = '{1'b0, 3'b010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
      vecs[5] = '{1'b1, 3'b101, 32'h0,          32'hFFFF_0000,  32'h0000_FFFF,  1'b0, 1'b0};
      vecs[6] = '{1'b0, 3'b000, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0};
      vecs[7] = '{1'b1, 3'b001, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'hFFFF_FFFF,  1'b0, 1'b0};
      vecs[8] = '{1'b0, 3'b100, 32'hFFFF_FFFF,  32'h0F0F_0F0F,  32'hF0F0_F0F0,  1'b0, 1'b0};
      vecs[9] = '{1'b1, 3'b111, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};

      rst           = 1'b1;
      bus.req_valid = 2'b00;
      bus.req_cmd0  = 3'b000;
      bus.req_cmd1  = 3'b000;
      bus.req_a0    = '0;
      bus.req_b0    = '0;
      bus.req_a1    = '0;
      bus.req_b1    = '0;
      bus.rsp_ready = 2'b00;
      #1;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Single-requester operations through the full handshake.
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].sel) begin
            bus.req_cmd1 = vecs[i].cmd; bus.req_a1 = vecs[i].a; bus.req_b1 = vecs[i].b;
            bus.req_cmd0 = 3'b010; bus.req_a0 = 32'h1234_5678; bus.req_b0 = 32'h1111_1111;
         end else begin
            bus.req_cmd0 = vecs[i].cmd; bus.req_a0 = vecs[i].a; bus.req_b0 = vecs[i].b;
            bus.req_cmd1 = 3'b010; bus.req_a1 = 32'h1234_5678; bus.req_b1 = 32'h1111_1111;
         end
         bus.req_valid = onehot(vecs[i].sel);
         #1;
         check($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(onehot(vecs[i].sel)));
         @(posedge clk); #1;
         bus.req_valid = 2'b00;
         check($sformatf("v%0d exec req_ready", i), 32'(bus.req_ready), 32'h0);
         check($sformatf("v%0d alu_cmd", i), 32'(bus.alu_cmd), 32'(vecs[i].cmd));
         check($sformatf("v%0d alu_a", i), bus.alu_a, vecs[i].a);
         check($sformatf("v%0d alu_b", i), bus.alu_b, vecs[i].b);
         check($sformatf("v%0d exec rsp_valid", i), 32'(bus.rsp_valid), 32'h0);
         @(posedge clk); #1;
         check($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(onehot(vecs[i].sel)));
         check($sformatf("v%0d rsp_res", i), bus.rsp_res, vecs[i].res);
         check($sformatf("v%0d rsp_zero", i), 32'(bus.rsp_zero), 32'(vecs[i].zero));
         check($sformatf("v%0d rsp_err", i), 32'(bus.rsp_err), 32'(vecs[i].err));
         check($sformatf("v%0d resp alu_a", i), bus.alu_a, 32'h0);
         bus.rsp_ready = onehot(vecs[i].sel);
         @(posedge clk); #1;
         check($sformatf("v%0d idle rsp_valid", i), 32'(bus.rsp_valid), 32'h0);
         bus.rsp_ready = 2'b00;
      end

      // Contention from reset: grants alternate 0,1,0,1.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.req_cmd0 = 3'b111; bus.req_a0 = 32'd3; bus.req_b0 = 32'd4;
      bus.req_cmd1 = 3'b110; bus.req_a1 = 32'd9; bus.req_b1 = 32'd9;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         logic exp_g;
         exp_g = (k % 2 == 1);
         #1;
         check($sformatf("rr%0d req_ready", k), 32'(bus.req_ready), 32'(onehot(exp_g)));
         @(posedge clk); #1;
         @(posedge clk); #1;
         check($sformatf("rr%0d rsp_valid", k), 32'(bus.rsp_valid), 32'(onehot(exp_g)));
         check($sformatf("rr%0d rsp_res", k), bus.rsp_res, exp_g ? 32'd0 : 32'd1);
         check($sformatf("rr%0d rsp_zero", k), 32'(bus.rsp_zero), exp_g ? 32'd1 : 32'd0);
         check($sformatf("rr%0d both high", k), 32'(|(bus.rsp_valid) && |(bus.req_ready)), 32'h0);
         @(posedge clk);
      end
      #1;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;

      // Response backpressure on requester 0.
      bus.req_cmd0 = 3'b000; bus.req_a0 = 32'h0000_00FF; bus.req_b0 = 32'h0000_000F;
      bus.req_valid = 2'b01;
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      @(posedge clk); #1;
      held = bus.rsp_res;
      check("bp first res", held, 32'h0000_000F);
      bus.req_valid = 2'b10;
      for (int c = 0; c < 5; c++) begin
         bus.rsp_ready = {~bus.rsp_ready[1], 1'b0};
         #1;
         check($sformatf("bp%0d rsp_valid", c), 32'(bus.rsp_valid), 32'h1);
         check($sformatf("bp%0d rsp_res", c), bus.rsp_res, held);
         check($sformatf("bp%0d req_ready", c), 32'(bus.req_ready), 32'h0);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 2'b01;
      @(posedge clk); #1;
      check("bp release rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("bp release idle req_ready", 32'(bus.req_ready), 32'h2);
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      #1;
      check("bp quiet req_ready", 32'(bus.req_ready), 32'h0);

      // Asynchronous reset in the middle of EXEC.
      bus.req_cmd0 = 3'b010; bus.req_a0 = 32'hAAAA_0001; bus.req_b0 = 32'h5555_0002;
      bus.req_cmd1 = 3'b010; bus.req_a1 = 32'hAAAA_0001; bus.req_b1 = 32'h5555_0002;
      bus.req_valid = 2'b11;
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      check("ar exec alu_a", bus.alu_a, 32'hAAAA_0001);
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs("async reset");
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("ar%0d no rsp_valid", c), 32'(bus.rsp_valid), 32'h0);
         @(posedge clk); #1;
      end
      bus.req_valid = 2'b11;
      #1;
      check("ar first grant", 32'(bus.req_ready), 32'h1);
      bus.req_valid = 2'b00;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
